mips_cpu_bus_arbiter: RTL
=========================

Name: mips_cpu_bus_arbiter

Overview:
- Two-master to one-slave Avalon-MM arbiter inside mips_cpu_bus.
- Shares the single external memory bus (address/read/write/waitrequest/writedata/byteenable/readdata) between the instruction-fetch port (read-only) and the load/store data port.
- Holds a grant for the whole transfer, including slave wait states, and returns status flags to the CPU control FSM.

Parameters:
- ADDR_W, 32, address width of both masters and the slave.
- DATA_W, 32, data width; byteenable width is DATA_W/8.

Ports:
- clk  input  1  single system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- i_address  input  ADDR_W  fetch address
- i_read  input  1  fetch request
- i_waitrequest  output  1  fetch stall
- i_readdata  output  DATA_W  fetch data
- d_address  input  ADDR_W  data address
- d_read  input  1  load request
- d_write  input  1  store request
- d_writedata  input  DATA_W  store data
- d_byteenable  input  DATA_W/8  store/load lane enables
- d_waitrequest  output  1  data stall
- d_readdata  output  DATA_W  load data
- address  output  ADDR_W  slave address
- read  output  1  slave read
- write  output  1  slave write
- writedata  output  DATA_W  slave write data
- byteenable  output  DATA_W/8  slave lane enables
- waitrequest  input  1  slave stall
- readdata  input  DATA_W  slave read data
- grant_i  output  1  state == GNT_I
- grant_d  output  1  state == GNT_D

Behaviour:
- Transfer rule:
  - A slave transfer completes in a cycle where (read|write) is high and waitrequest is low.
  - readdata is valid in that same cycle.
- FSM states IDLE, GNT_I, GNT_D (registered).
- IDLE:
  - d request (d_read|d_write) -> GNT_D.
  - Else i_read -> GNT_I.
  - Else stay.
  - Fixed priority: data port wins when both request.
- GNT_x:
  - Slave outputs are muxed combinationally from master x.
  - Instruction port drives write=0, writedata=0, byteenable=all ones.
  - Completion -> IDLE. Each transfer therefore costs at least 2 cycles: 1 arbitration bubble + 1 slave cycle.
- Master dropping its request while granted (protocol violation): -> IDLE next edge, no transfer counted, slave read/write low from that cycle.
- d_read and d_write both high: treated as write; read output forced 0.
- Outputs in IDLE:
  - address=0, read=0, write=0, writedata=0, byteenable=0.
  - grant_i=grant_d=0.
- Master waitrequest:
  - x_waitrequest = !(state==GNT_x && !waitrequest).
  - Both are high in IDLE and while the other master is granted.
  - Both are high during reset.
- i_readdata = d_readdata = readdata (broadcast); masters qualify it with their own waitrequest.
- Reset:
  - The edge with reset high forces IDLE.
  - If asserted mid-transfer, slave read/write go low the following cycle and the transfer is abandoned.
  - Reset has priority over all transitions.
  - Priority pointer (optional feature) resets to "data last served", so instruction wins first contention.
- Starvation: under fixed priority, continuous d requests starve fetch. This is acceptable for a multicycle CPU, which never requests both ports back-to-back.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined:
  - 1-bit last_served register, updated on each completed transfer.
  - When both request in IDLE, the master not last served wins.
  - Single requester always wins.
- Undefined: fixed data-over-instruction priority, no extra register.

Test Plan:
- Single fetch:
  - Stimulus: i_read=1, i_address=0xBFC00000; slave waitrequest low, readdata=0x3C03BFC0.
  - Required: grant_i one cycle later; i_waitrequest low in cycle 2; i_readdata=0x3C03BFC0; back to IDLE.
- Store with wait states:
  - Stimulus: d_write=1, d_address=0xBFC00028, d_writedata=0x8C6780B8, d_byteenable=4'b0011; slave waitrequest high for 3 cycles.
  - Required: write/address/writedata/byteenable held stable for 4 slave cycles; d_waitrequest low only in the 4th; RAM word updated on the low half only.
- Contention:
  - Stimulus: i_read and d_read asserted in the same cycle.
  - Required, fixed priority: grant_d first, then a bubble cycle, then grant_i.
  - Required, ARB_ROUND_ROBIN_EN after reset: grant_i first, then grant_d.
- Reset mid-transfer:
  - Stimulus: reset pulsed for 1 cycle during GNT_D with slave waitrequest high.
  - Required: next cycle read=write=0, grant_d=0, d_waitrequest=1, state IDLE.
- Protocol edge cases:
  - Stimulus: d_read and d_write both high.
  - Required: only write=1 on the slave.
  - Stimulus: i_read dropped while in GNT_I with waitrequest high.
  - Required: IDLE next cycle, no read outstanding.
- Full CPU integration:
  - Stimulus: mips_cpu_bus with RAM running the beq program from reset vector 0xBFC00000.
  - Required: active falls and register_v0=0x8C6780B8.

Source files
------------

// File: rtl/mips_cpu_bus_arbiter_if.sv
// Bus bundle between the fetch/data masters, the arbiter and the external Avalon-MM slave.
// The arbiter connects through the slave modport; the environment drives the master modport.
interface mips_cpu_bus_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned BE_W = DATA_W / 8;

  // Instruction-fetch master (read-only)
  logic [ADDR_W-1:0] i_address;
  logic              i_read;
  logic              i_waitrequest;
  logic [DATA_W-1:0] i_readdata;

  // Load/store master
  logic [ADDR_W-1:0] d_address;
  logic              d_read;
  logic              d_write;
  logic [DATA_W-1:0] d_writedata;
  logic [BE_W-1:0]   d_byteenable;
  logic              d_waitrequest;
  logic [DATA_W-1:0] d_readdata;

  // Shared external slave
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic [BE_W-1:0]   byteenable;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;

  // Status to the CPU control FSM
  logic              grant_i;
  logic              grant_d;

  modport slave (
    input  i_address, i_read,
    output i_waitrequest, i_readdata,
    input  d_address, d_read, d_write, d_writedata, d_byteenable,
    output d_waitrequest, d_readdata,
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata,
    output grant_i, grant_d
  );

  modport master (
    output i_address, i_read,
    input  i_waitrequest, i_readdata,
    output d_address, d_read, d_write, d_writedata, d_byteenable,
    input  d_waitrequest, d_readdata,
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata,
    input  grant_i, grant_d
  );
endinterface

// File: rtl/mips_cpu_bus_arbiter.sv
// Two-master (fetch, load/store) to one-slave Avalon-MM arbiter holding the grant for a whole
// transfer. Define ARB_ROUND_ROBIN_EN for alternating priority; default is data-over-fetch.
module mips_cpu_bus_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input logic                 clk,
  input logic                 reset,
  mips_cpu_bus_arbiter_if.slave bus
);
  localparam int unsigned BE_W = DATA_W / 8;

  typedef enum logic [1:0] {StIdle, StGntI, StGntD} state_e;

  state_e state_q, state_d;
  logic   grant_i_q, grant_d_q;
  logic   d_req;

  logic [ADDR_W-1:0] slv_address;
  logic              slv_read;
  logic              slv_write;
  logic [DATA_W-1:0] slv_writedata;
  logic [BE_W-1:0]   slv_byteenable;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_served_d_q;  // 1: data port served most recently
  logic xfer_done;
  assign xfer_done = (slv_read | slv_write) & ~bus.waitrequest;
`endif

  assign d_req = bus.d_read | bus.d_write;

  // Slave side is a pure mux of the granted master; a dropped request drops read/write at once.
  always_comb begin
    slv_address    = '0;
    slv_read       = 1'b0;
    slv_write      = 1'b0;
    slv_writedata  = '0;
    slv_byteenable = '0;
    unique case (state_q)
      StGntI: begin
        slv_address    = bus.i_address;
        slv_read       = bus.i_read;
        slv_byteenable = '1;
      end
      StGntD: begin
        slv_address    = bus.d_address;
        slv_write      = bus.d_write;
        slv_read       = bus.d_read & ~bus.d_write;
        slv_writedata  = bus.d_writedata;
        slv_byteenable = bus.d_byteenable;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (d_req && bus.i_read) begin
`ifdef ARB_ROUND_ROBIN_EN
          state_d = last_served_d_q ? StGntI : StGntD;
`else
          state_d = StGntD;
`endif
        end else if (d_req) begin
          state_d = StGntD;
        end else if (bus.i_read) begin
          state_d = StGntI;
        end
      end
      // Leave on completion or on a request withdrawn mid-transfer.
      StGntI: if (!bus.i_read || !bus.waitrequest) state_d = StIdle;
      StGntD: if (!d_req || !bus.waitrequest) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      grant_i_q <= 1'b0;
      grant_d_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_served_d_q <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      grant_i_q <= (state_d == StGntI);
      grant_d_q <= (state_d == StGntD);
`ifdef ARB_ROUND_ROBIN_EN
      if (xfer_done) last_served_d_q <= (state_q == StGntD);
`endif
    end
  end

  assign bus.address    = slv_address;
  assign bus.read       = slv_read;
  assign bus.write      = slv_write;
  assign bus.writedata  = slv_writedata;
  assign bus.byteenable = slv_byteenable;

  assign bus.grant_i = grant_i_q;
  assign bus.grant_d = grant_d_q;

  assign bus.i_waitrequest = reset | ~(grant_i_q & ~bus.waitrequest);
  assign bus.d_waitrequest = reset | ~(grant_d_q & ~bus.waitrequest);

  assign bus.i_readdata = bus.readdata;
  assign bus.d_readdata = bus.readdata;
endmodule
